// File: rtl/bcd_transform_ctrl.sv
// Sequencer for the 3-digit BCD code-transform datapath: serial digit capture, settle, result hold.
// Optional capture-time code check enabled by defining BCD_TRANSFORM_CHECK_EN.
module bcd_transform_ctrl #(
    parameter int SETTLE_CYCLES = 1,
    parameter int TIMEOUT       = 255
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        CLR,
    input  logic        DIG_VALID,
    input  logic [3:0]  DIG,
    output logic        DIG_READY,
    output logic [11:0] XF_IN,
    input  logic [14:0] XF_OUT,
    input  logic [9:0]  XF_DEC,
    output logic        RES_VALID,
    input  logic        RES_READY,
    output logic [14:0] RES_CODE,
    output logic [9:0]  RES_DEC,
    output logic [1:0]  RES_MODE,
    output logic        ERR,
    output logic [7:0]  CNT
);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_SETTLE, S_HOLD} state_t;

    localparam logic [3:0] SETTLE_LAST  = 4'(SETTLE_CYCLES);
    localparam logic [7:0] TIMEOUT_LAST = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);
    localparam logic       TIMEOUT_EN   = (TIMEOUT != 0);

    function automatic logic [9:0] bcd_value(input logic [11:0] w);
        return ({6'd0, w[11:8]} * 10'd100) + ({6'd0, w[7:4]} * 10'd10) + {6'd0, w[3:0]};
    endfunction

    function automatic logic [1:0] range_mode(input logic [9:0] v);
        logic [1:0] m;
        if (v < 10'd100) begin
            m = 2'd0;
        end else if (v < 10'd450) begin
            m = 2'd1;
        end else if (v < 10'd900) begin
            m = 2'd2;
        end else begin
            m = 2'd3;
        end
        return m;
    endfunction

`ifdef BCD_TRANSFORM_CHECK_EN
    function automatic logic two_hot(input logic [4:0] f);
        logic [2:0] n;
        n = {2'd0, f[0]} + {2'd0, f[1]} + {2'd0, f[2]} + {2'd0, f[3]} + {2'd0, f[4]};
        return (n == 3'd2);
    endfunction

    function automatic logic e3_ok(input logic [4:0] f);
        return (f >= 5'd3) && (f <= 5'd12);
    endfunction

    function automatic logic code_ok(input logic [1:0] m, input logic [14:0] c);
        logic ok;
        case (m)
            2'd0:    ok = e3_ok(c[14:10]) && e3_ok(c[9:5]) && e3_ok(c[4:0]);
            2'd1,
            2'd2:    ok = two_hot(c[14:10]) && two_hot(c[9:5]) && two_hot(c[4:0]);
            default: ok = 1'b1;
        endcase
        return ok;
    endfunction
`endif

    state_t      state_r, state_s;
    logic [1:0]  idx_r, idx_s;
    logic [3:0]  hund_r, hund_s, tens_r, tens_s;
    logic [7:0]  idle_cnt_r, idle_cnt_s;
    logic [3:0]  settle_cnt_r, settle_cnt_s;
    logic [11:0] xf_in_r, xf_in_s;
    logic        res_valid_r, res_valid_s;
    logic [14:0] res_code_r, res_code_s;
    logic [9:0]  res_dec_r, res_dec_s;
    logic [1:0]  res_mode_r, res_mode_s;
    logic        err_r, err_s;
    logic [7:0]  cnt_r, cnt_s;
    logic        dig_ready_r, dig_ready_s;
    logic        accept_s, bad_s;
    logic [1:0]  mode_s;

    assign accept_s = DIG_VALID && dig_ready_r;
    assign bad_s    = (DIG > 4'd9);
    assign mode_s   = range_mode(bcd_value(xf_in_r));

    // Next-state and next-output logic; CLR overrides every state's transition.
    always_comb begin
        state_s      = state_r;
        idx_s        = idx_r;
        hund_s       = hund_r;
        tens_s       = tens_r;
        idle_cnt_s   = idle_cnt_r;
        settle_cnt_s = settle_cnt_r;
        xf_in_s      = xf_in_r;
        res_valid_s  = res_valid_r;
        res_code_s   = res_code_r;
        res_dec_s    = res_dec_r;
        res_mode_s   = res_mode_r;
        err_s        = 1'b0;
        cnt_s        = cnt_r;
        if (CLR) begin
            state_s     = S_IDLE;
            res_valid_s = 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (accept_s && bad_s) begin
                        err_s = 1'b1;
                    end else if (accept_s) begin
                        hund_s     = DIG;
                        idx_s      = 2'd1;
                        idle_cnt_s = 8'd0;
                        state_s    = S_COLLECT;
                    end else begin
                        state_s = S_IDLE;
                    end
                end
                S_COLLECT: begin
                    // An accepted digit takes precedence over an expiring idle counter.
                    if (accept_s && bad_s) begin
                        err_s   = 1'b1;
                        state_s = S_IDLE;
                    end else if (accept_s && (idx_r == 2'd1)) begin
                        tens_s     = DIG;
                        idx_s      = 2'd2;
                        idle_cnt_s = 8'd0;
                    end else if (accept_s) begin
                        xf_in_s      = {hund_r, tens_r, DIG};
                        settle_cnt_s = 4'd0;
                        state_s      = S_SETTLE;
                    end else if (TIMEOUT_EN && (idle_cnt_r == TIMEOUT_LAST)) begin
                        err_s   = 1'b1;
                        state_s = S_IDLE;
                    end else begin
                        idle_cnt_s = idle_cnt_r + 8'd1;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt_r == SETTLE_LAST) begin
                        res_valid_s = 1'b1;
                        res_mode_s  = mode_s;
                        state_s     = S_HOLD;
                        if (mode_s == 2'd3) begin
                            res_code_s = 15'd0;
                            res_dec_s  = XF_DEC;
                        end else begin
                            res_code_s = XF_OUT;
                            res_dec_s  = 10'd0;
                        end
`ifdef BCD_TRANSFORM_CHECK_EN
                        if (!code_ok(mode_s, XF_OUT)) begin
                            err_s = 1'b1;
                        end else begin
                            err_s = 1'b0;
                        end
`endif
                    end else begin
                        settle_cnt_s = settle_cnt_r + 4'd1;
                    end
                end
                S_HOLD: begin
                    if (RES_READY) begin
                        res_valid_s = 1'b0;
                        cnt_s       = cnt_r + 8'd1;
                        state_s     = S_IDLE;
                    end else begin
                        res_valid_s = 1'b1;
                    end
                end
                default: state_s = S_IDLE;
            endcase
        end
        dig_ready_s = (state_s == S_IDLE) || (state_s == S_COLLECT);
    end

    // FSM state register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            idx_r        <= 2'd0;
            hund_r       <= 4'd0;
            tens_r       <= 4'd0;
            idle_cnt_r   <= 8'd0;
            settle_cnt_r <= 4'd0;
            xf_in_r      <= 12'd0;
            res_valid_r  <= 1'b0;
            res_code_r   <= 15'd0;
            res_dec_r    <= 10'd0;
            res_mode_r   <= 2'd0;
            err_r        <= 1'b0;
            cnt_r        <= 8'd0;
            dig_ready_r  <= 1'b0;
        end else begin
            idx_r        <= idx_s;
            hund_r       <= hund_s;
            tens_r       <= tens_s;
            idle_cnt_r   <= idle_cnt_s;
            settle_cnt_r <= settle_cnt_s;
            xf_in_r      <= xf_in_s;
            res_valid_r  <= res_valid_s;
            res_code_r   <= res_code_s;
            res_dec_r    <= res_dec_s;
            res_mode_r   <= res_mode_s;
            err_r        <= err_s;
            cnt_r        <= cnt_s;
            dig_ready_r  <= dig_ready_s;
        end
    end

    assign DIG_READY = dig_ready_r;
    assign XF_IN     = xf_in_r;
    assign RES_VALID = res_valid_r;
    assign RES_CODE  = res_code_r;
    assign RES_DEC   = res_dec_r;
    assign RES_MODE  = res_mode_r;
    assign ERR       = err_r;
    assign CNT       = cnt_r;

endmodule

// File: tb/tb_bcd_transform_ctrl.sv
// Directed bench for bcd_transform_ctrl with a behavioural code-transform datapath and result scoreboard.
module tb_bcd_transform_ctrl;

    localparam int SETTLE = 1;
    localparam int TO     = 5;

    logic        CLK = 1'b0;
    logic        RST_N, CLR, DIG_VALID, RES_READY;
    logic [3:0]  DIG;
    logic        DIG_READY, RES_VALID, ERR;
    logic [11:0] XF_IN;
    logic [14:0] XF_OUT, RES_CODE;
    logic [9:0]  XF_DEC, RES_DEC;
    logic [1:0]  RES_MODE;
    logic [7:0]  CNT;

    typedef struct packed {
        logic [14:0] code;
        logic [9:0]  dec;
        logic [1:0]  mode;
    } res_t;

    res_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [7:0]  exp_cnt;
    logic        corrupt;

    bcd_transform_ctrl #(.SETTLE_CYCLES(SETTLE), .TIMEOUT(TO)) dut (
        .CLK(CLK), .RST_N(RST_N), .CLR(CLR), .DIG_VALID(DIG_VALID), .DIG(DIG),
        .DIG_READY(DIG_READY), .XF_IN(XF_IN), .XF_OUT(XF_OUT), .XF_DEC(XF_DEC),
        .RES_VALID(RES_VALID), .RES_READY(RES_READY), .RES_CODE(RES_CODE),
        .RES_DEC(RES_DEC), .RES_MODE(RES_MODE), .ERR(ERR), .CNT(CNT)
    );

    always #5 CLK = ~CLK;

    function automatic logic [9:0] val(input logic [11:0] w);
        return 10'(w[11:8]) * 10'd100 + 10'(w[7:4]) * 10'd10 + 10'(w[3:0]);
    endfunction

    function automatic logic [1:0] cls(input logic [9:0] v);
        if (v < 10'd100) return 2'd0;
        else if (v < 10'd450) return 2'd1;
        else if (v < 10'd900) return 2'd2;
        else return 2'd3;
    endfunction

    function automatic logic [4:0] c74(input logic [3:0] d);
        case (d)
            4'd0: return 5'b11000;  4'd1: return 5'b00011;  4'd2: return 5'b00101;
            4'd3: return 5'b00110;  4'd4: return 5'b01001;  4'd5: return 5'b01010;
            4'd6: return 5'b01100;  4'd7: return 5'b10001;  4'd8: return 5'b10010;
            default: return 5'b10100;
        endcase
    endfunction

    function automatic logic [4:0] c63(input logic [3:0] d);
        case (d)
            4'd0: return 5'b00110;  4'd1: return 5'b00011;  4'd2: return 5'b00101;
            4'd3: return 5'b01001;  4'd4: return 5'b01010;  4'd5: return 5'b01100;
            4'd6: return 5'b10001;  4'd7: return 5'b10010;  4'd8: return 5'b10100;
            default: return 5'b11000;
        endcase
    endfunction

    function automatic logic [4:0] enc(input logic [1:0] m, input logic [3:0] d);
        case (m)
            2'd0:    return {1'b0, d} + 5'd3;
            2'd1:    return c74(d);
            2'd2:    return c63(d);
            default: return {1'b0, d};
        endcase
    endfunction

    function automatic logic [14:0] code_of(input logic [11:0] w);
        logic [1:0] m;
        m = cls(val(w));
        return {enc(m, w[11:8]), enc(m, w[7:4]), enc(m, w[3:0])};
    endfunction

    // Behavioural datapath; corrupt forces an illegal units field.
    always_comb begin
        XF_OUT = code_of(XF_IN);
        if (corrupt) XF_OUT[4:0] = 5'b00111;
        XF_DEC = val(XF_IN);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [11:0] w);
        res_t e;
        logic [9:0] v;
        v = val(w);
        e.mode = cls(v);
        e.code = (e.mode == 2'd3) ? 15'd0 : code_of(w);
        e.dec  = (e.mode == 2'd3) ? v : 10'd0;
        sb.push_back(e);
    endtask

    task automatic send_digit(input logic [3:0] d);
        int n;
        n = 0;
        DIG_VALID = 1'b1;
        DIG = d;
        while (DIG_READY !== 1'b1 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        check("dig_ready_wait", 32'(n < 50), 32'd1);
        @(posedge CLK);
        #1;
        DIG_VALID = 1'b0;
        DIG = 4'd0;
    endtask

    task automatic start_number(input logic [3:0] h, input logic [3:0] t, input logic [3:0] u);
        push_exp({h, t, u});
        send_digit(h);
        send_digit(t);
        send_digit(u);
    endtask

    task automatic wait_result(input logic [11:0] w);
        int n;
        res_t e;
        n = 0;
        do begin
            @(posedge CLK);
            #1;
            n++;
        end while (RES_VALID !== 1'b1 && n < 40);
        check("latency", 32'(n), 32'(SETTLE + 1));
        check("xf_in", 32'(XF_IN), 32'(w));
        check("err_at_capture", 32'(ERR), 32'd0);
        check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("res_code", 32'(RES_CODE), 32'(e.code));
            check("res_dec", 32'(RES_DEC), 32'(e.dec));
            check("res_mode", 32'(RES_MODE), 32'(e.mode));
        end
    endtask

    task automatic consume();
        RES_READY = 1'b1;
        @(posedge CLK);
        #1;
        exp_cnt = exp_cnt + 8'd1;
        check("consume_valid_low", 32'(RES_VALID), 32'd0);
        check("cnt", 32'(CNT), 32'(exp_cnt));
        RES_READY = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_dig_ready"}, 32'(DIG_READY), 32'd0);
        check({tag, "_xf_in"}, 32'(XF_IN), 32'd0);
        check({tag, "_res_valid"}, 32'(RES_VALID), 32'd0);
        check({tag, "_res_code"}, 32'(RES_CODE), 32'd0);
        check({tag, "_res_dec"}, 32'(RES_DEC), 32'd0);
        check({tag, "_res_mode"}, 32'(RES_MODE), 32'd0);
        check({tag, "_err"}, 32'(ERR), 32'd0);
        check({tag, "_cnt"}, 32'(CNT), 32'd0);
    endtask

    initial begin
        logic [14:0] prev_code;
        int first, errs, n, need;
        RST_N = 1'b0; CLR = 1'b0; DIG_VALID = 1'b0; DIG = 4'd0;
        RES_READY = 1'b0; corrupt = 1'b0; exp_cnt = 8'd0;
        repeat (3) @(negedge CLK);
        check_all_zero("reset");
        RST_N = 1'b1;

        // Mode 0 with consumer always ready
        RES_READY = 1'b1;
        start_number(4'd0, 4'd4, 4'd7);
        wait_result(12'h047);
        check("e3_const", 32'(RES_CODE), 32'(15'b00011_00111_01010));
        consume();
        check("cnt_first", 32'(CNT), 32'd1);

        start_number(4'd3, 4'd2, 4'd1);
        wait_result(12'h321);
        check("c74210_const", 32'(RES_CODE), 32'(15'b00110_00101_00011));
        consume();
        start_number(4'd4, 4'd5, 4'd0);
        wait_result(12'h450);
        check("c63210_const", 32'(RES_CODE), 32'(15'b01010_01100_00110));
        consume();
        start_number(4'd0, 4'd9, 4'd9);
        wait_result(12'h099);
        consume();
        start_number(4'd8, 4'd9, 4'd9);
        wait_result(12'h899);
        consume();

        // Decimal mode, consumer stalls for 10 cycles
        start_number(4'd9, 4'd5, 4'd6);
        wait_result(12'h956);
        check("dec_const", 32'(RES_DEC), 32'd956);
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK);
            #1;
            check("hold_valid", 32'(RES_VALID), 32'd1);
            check("hold_dec", 32'(RES_DEC), 32'd956);
            check("hold_code", 32'(RES_CODE), 32'd0);
            check("hold_mode", 32'(RES_MODE), 32'd3);
            check("hold_dig_ready", 32'(DIG_READY), 32'd0);
        end
        consume();
        check("cnt_once", 32'(CNT), 32'd6);

        // Bad digit in COLLECT and in IDLE
        send_digit(4'd1);
        send_digit(4'd12);
        check("bad_err", 32'(ERR), 32'd1);
        check("bad_xf_in", 32'(XF_IN), 32'h956);
        check("bad_dig_ready", 32'(DIG_READY), 32'd1);
        @(posedge CLK); #1;
        check("bad_err_pulse", 32'(ERR), 32'd0);
        send_digit(4'd10);
        check("bad_idle_err", 32'(ERR), 32'd1);
        check("bad_idle_xf_in", 32'(XF_IN), 32'h956);
        start_number(4'd1, 4'd2, 4'd3);
        wait_result(12'h123);
        consume();

        // Idle timeout after one digit
        send_digit(4'd2);
        first = 0; errs = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge CLK); #1;
            if (ERR === 1'b1) begin
                errs++;
                if (first == 0) first = k;
            end
        end
        check("timeout_cycle", 32'(first), 32'(TO));
        check("timeout_pulses", 32'(errs), 32'd1);
        check("timeout_dig_ready", 32'(DIG_READY), 32'd1);

        // Digit arriving on the expiry cycle wins
        push_exp(12'h234);
        send_digit(4'd2);
        repeat (TO - 1) @(posedge CLK);
        #1;
        send_digit(4'd3);
        check("race_no_err", 32'(ERR), 32'd0);
        send_digit(4'd4);
        wait_result(12'h234);
        consume();

        // CLR during SETTLE
        prev_code = RES_CODE;
        send_digit(4'd5); send_digit(4'd5); send_digit(4'd5);
        CLR = 1'b1;
        @(posedge CLK); #1;
        CLR = 1'b0;
        check("clr_valid", 32'(RES_VALID), 32'd0);
        check("clr_err", 32'(ERR), 32'd0);
        check("clr_cnt", 32'(CNT), 32'(exp_cnt));
        check("clr_xf_in", 32'(XF_IN), 32'h555);
        check("clr_code", 32'(RES_CODE), 32'(prev_code));
        check("clr_dig_ready", 32'(DIG_READY), 32'd1);
        repeat (4) @(posedge CLK);
        #1;
        check("clr_no_result", 32'(RES_VALID), 32'd0);

        // Asynchronous reset while holding a result
        start_number(4'd8, 4'd0, 4'd0);
        wait_result(12'h800);
        #2;
        RST_N = 1'b0;
        #1;
        check_all_zero("rst_hold");
        @(negedge CLK);
        RST_N = 1'b1;
        exp_cnt = 8'd0;

        // Illegal two-of-five field in mode 1
        corrupt = 1'b1;
        send_digit(4'd3); send_digit(4'd2); send_digit(4'd1);
        n = 0;
        do begin
            @(posedge CLK); #1; n++;
        end while (RES_VALID !== 1'b1 && n < 40);
        check("chk_latency", 32'(n), 32'(SETTLE + 1));
        check("chk_units_field", 32'(RES_CODE[4:0]), 32'(5'b00111));
`ifdef BCD_TRANSFORM_CHECK_EN
        check("chk_err", 32'(ERR), 32'd1);
`else
        check("chk_err", 32'(ERR), 32'd0);
`endif
        consume();
        corrupt = 1'b0;

        // Counter wrap
        need = 256 - int'(exp_cnt);
        for (int i = 0; i < need; i++) begin
            logic [3:0] h, t, u;
            h = 4'($urandom_range(0, 9));
            t = 4'($urandom_range(0, 9));
            u = 4'($urandom_range(0, 9));
            start_number(h, t, u);
            wait_result({h, t, u});
            consume();
            if (i == need - 2) check("cnt_255", 32'(CNT), 32'd255);
        end
        check("cnt_wrap", 32'(CNT), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
